// File: rtl/cache_set.sv
`default_nettype none
// ============================================================================
// Module   : cache_set
// Purpose  : One set of a write-back, write-allocate cache. WAYS lines, each
//            holding valid, dirty, tag and 2^OFFSET_BITS words. Misses evict a
//            dirty victim word by word, then refill the line from memory.
// Config   : CACHE_SET_LRU_EN defined   -> true LRU with per-way age counters
//            CACHE_SET_LRU_EN undefined -> round-robin allocation pointer
// Revision : 1.0 - initial release
// ============================================================================
module cache_set #(
  parameter int ADDRESS_WORD_SIZE = 32,
  parameter int TAG_SIZE          = 19,
  parameter int WORD_SIZE         = 8,
  parameter int WAYS              = 4,
  parameter int OFFSET_BITS       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDRESS_WORD_SIZE-1:0] i_addr,
  input  logic                         i_try_read,
  input  logic                         i_try_write,
  input  logic [WORD_SIZE-1:0]         i_write_data,
  output logic [WORD_SIZE-1:0]         o_read_data,
  output logic                         o_hit,
  output logic                         o_done,
  output logic                         o_busy,
  output logic                         o_mem_req,
  output logic                         o_mem_we,
  output logic [ADDRESS_WORD_SIZE-1:0] o_mem_addr,
  output logic [WORD_SIZE-1:0]         o_mem_wdata,
  input  logic [WORD_SIZE-1:0]         i_mem_rdata,
  input  logic                         i_mem_ack
);

  localparam int c_WORDS = 1 << OFFSET_BITS;
  localparam int c_WAY_W = $clog2(WAYS);
  localparam int c_MID_W = ADDRESS_WORD_SIZE - TAG_SIZE - OFFSET_BITS;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EVICT   = 2'd1,
    S_REFILL  = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  // Line storage
  logic [WAYS-1:0]      r_valid;
  logic [WAYS-1:0]      r_dirty;
  logic [TAG_SIZE-1:0]  r_tag  [WAYS];
  logic [WORD_SIZE-1:0] r_data [WAYS][c_WORDS];

  // Control state
  state_t                 r_state;
  state_t                 w_state_next;
  logic [OFFSET_BITS-1:0] r_cnt;
  logic [c_WAY_W-1:0]     r_victim;
  logic                   r_done;
  logic [WORD_SIZE-1:0]   r_read_data;

  // Captured miss request
  logic [TAG_SIZE-1:0]    r_cap_tag;
  logic [c_MID_W-1:0]     r_cap_mid;
  logic [OFFSET_BITS-1:0] r_cap_off;
  logic [WORD_SIZE-1:0]   r_cap_data;
  logic                   r_cap_write;

  // Address fields of the incoming request
  logic [TAG_SIZE-1:0]    w_addr_tag;
  logic [c_MID_W-1:0]     w_addr_mid;
  logic [OFFSET_BITS-1:0] w_addr_off;

  // Lookup / decision wires
  logic                   w_req;
  logic                   w_hit;
  logic [c_WAY_W-1:0]     w_hit_way;
  logic                   w_free_found;
  logic [c_WAY_W-1:0]     w_free_way;
  logic [c_WAY_W-1:0]     w_policy_way;
  logic [c_WAY_W-1:0]     w_victim;
  logic                   w_hit_acc;
  logic                   w_miss_acc;
  logic                   w_last;
  logic                   w_xfer_ack;
  logic                   w_refill_ack;
  logic                   w_alloc;
  logic                   w_touch_en;
  logic [c_WAY_W-1:0]     w_touch_way;

  // Data array write port
  logic                   w_wr_en;
  logic [c_WAY_W-1:0]     w_wr_way;
  logic [OFFSET_BITS-1:0] w_wr_off;
  logic [WORD_SIZE-1:0]   w_wr_val;

  assign w_addr_tag = i_addr[ADDRESS_WORD_SIZE-1 -: TAG_SIZE];
  assign w_addr_mid = i_addr[ADDRESS_WORD_SIZE-TAG_SIZE-1 : OFFSET_BITS];
  assign w_addr_off = i_addr[OFFSET_BITS-1:0];

  // A read and write strobe together is handled as a write
  assign w_req        = i_try_read | i_try_write;
  assign w_hit_acc    = (r_state == S_IDLE) && w_req && w_hit;
  assign w_miss_acc   = (r_state == S_IDLE) && w_req && !w_hit;
  assign w_last       = (r_cnt == {OFFSET_BITS{1'b1}});
  assign w_xfer_ack   = ((r_state == S_EVICT) || (r_state == S_REFILL)) && i_mem_ack;
  assign w_refill_ack = (r_state == S_REFILL) && i_mem_ack;
  assign w_alloc      = w_refill_ack && w_last;
  assign w_touch_en   = w_hit_acc || w_alloc;
  assign w_touch_way  = w_hit_acc ? w_hit_way : r_victim;

  assign o_hit       = w_hit;
  assign o_done      = r_done;
  assign o_read_data = r_read_data;
  assign o_busy      = (r_state != S_IDLE);

  // Tag lookup: lowest-index valid way whose tag matches the request
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_tag[i] == w_addr_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = c_WAY_W'(i);
      end
    end
  end

  // Victim choice: an invalid way (lowest index) beats the replacement policy
  always_comb begin
    w_free_found = 1'b0;
    w_free_way   = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_found = 1'b1;
        w_free_way   = c_WAY_W'(i);
      end
    end
    w_victim = w_free_found ? w_free_way : w_policy_way;
  end

`ifdef CACHE_SET_LRU_EN
  logic [c_WAY_W-1:0] r_age      [WAYS];
  logic [c_WAY_W-1:0] w_age_next [WAYS];

  // Oldest way (age WAYS-1) is the policy victim
  always_comb begin
    w_policy_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (r_age[i] == {c_WAY_W{1'b1}}) begin
        w_policy_way = c_WAY_W'(i);
      end
    end
  end

  // Age update: touched way becomes youngest, ways not older than it age by
  // one. Using <= (not <) lets the all-zero reset ages settle into a
  // permutation as ways are allocated; ages saturate at WAYS-1.
  always_comb begin
    for (int i = 0; i < WAYS; i++) begin
      w_age_next[i] = r_age[i];
      if (w_touch_en) begin
        if (c_WAY_W'(i) == w_touch_way) begin
          w_age_next[i] = '0;
        end else if ((r_age[i] <= r_age[w_touch_way]) &&
                     (r_age[i] != {c_WAY_W{1'b1}})) begin
          w_age_next[i] = r_age[i] + 1'b1;
        end
      end
    end
  end

  // Age counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WAYS; i++) begin
        r_age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WAYS; i++) begin
        r_age[i] <= w_age_next[i];
      end
    end
  end
`else
  logic [c_WAY_W-1:0] r_rr_ptr;

  assign w_policy_way = r_rr_ptr;

  // Round-robin pointer advances once per completed line allocation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_alloc) begin
      r_rr_ptr <= r_rr_ptr + 1'b1;
    end
  end
`endif

  // Data array write source: hit store, or refill word with the pending
  // store merged in so the line is never written twice at the same offset
  always_comb begin
    w_wr_en  = 1'b0;
    w_wr_way = '0;
    w_wr_off = '0;
    w_wr_val = '0;
    if (w_hit_acc && i_try_write) begin
      w_wr_en  = 1'b1;
      w_wr_way = w_hit_way;
      w_wr_off = w_addr_off;
      w_wr_val = i_write_data;
    end else if (w_refill_ack) begin
      w_wr_en  = 1'b1;
      w_wr_way = r_victim;
      w_wr_off = r_cnt;
      w_wr_val = (r_cap_write && (r_cnt == r_cap_off)) ? r_cap_data : i_mem_rdata;
    end
  end

  // Tag and data storage; validity is tracked separately so no reset needed
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_data[w_wr_way][w_wr_off] <= w_wr_val;
    end
    if (w_alloc) begin
      r_tag[r_victim] <= r_cap_tag;
    end
  end

  // Next-state and memory-port outputs
  always_comb begin
    w_state_next = r_state;
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_miss_acc) begin
          w_state_next = (r_valid[w_victim] && r_dirty[w_victim]) ? S_EVICT : S_REFILL;
        end
      end
      S_EVICT: begin
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = {r_tag[r_victim], r_cap_mid, r_cnt};
        o_mem_wdata = r_data[r_victim][r_cnt];
        if (i_mem_ack && w_last) begin
          w_state_next = S_REFILL;
        end
      end
      S_REFILL: begin
        o_mem_req  = 1'b1;
        o_mem_addr = {r_cap_tag, r_cap_mid, r_cnt};
        if (i_mem_ack && w_last) begin
          w_state_next = S_RESPOND;
        end
      end
      S_RESPOND: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register, request capture, line status and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_valid     <= '0;
      r_dirty     <= '0;
      r_victim    <= '0;
      r_done      <= 1'b0;
      r_read_data <= '0;
      r_cap_tag   <= '0;
      r_cap_mid   <= '0;
      r_cap_off   <= '0;
      r_cap_data  <= '0;
      r_cap_write <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;

      if (w_hit_acc) begin
        r_done      <= 1'b1;
        r_read_data <= i_try_write ? i_write_data : r_data[w_hit_way][w_addr_off];
        if (i_try_write) begin
          r_dirty[w_hit_way] <= 1'b1;
        end
      end

      // Victim is invalidated at acceptance so a half-refilled line can never
      // report a hit; its old tag and dirty status are still used for EVICT
      if (w_miss_acc) begin
        r_cap_tag          <= w_addr_tag;
        r_cap_mid          <= w_addr_mid;
        r_cap_off          <= w_addr_off;
        r_cap_data         <= i_write_data;
        r_cap_write        <= i_try_write;
        r_victim           <= w_victim;
        r_cnt              <= '0;
        r_valid[w_victim]  <= 1'b0;
        r_dirty[w_victim]  <= 1'b0;
      end

      // Counter wraps to zero after the last word, ready for the next phase
      if (w_xfer_ack) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_refill_ack && (r_cnt == r_cap_off)) begin
        r_read_data <= r_cap_write ? r_cap_data : i_mem_rdata;
      end

      if (w_alloc) begin
        r_valid[r_victim] <= 1'b1;
        r_dirty[r_victim] <= r_cap_write;
        r_done            <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/cache_set.md
CACHE_SET -- requirements
Module: cache_set

Interface
REQ-001 SHALL have parameter ADDRESS_WORD_SIZE, default 32, byte address width.
REQ-002 SHALL have parameter TAG_SIZE, default 19, tag taken from addr[ADDRESS_WORD_SIZE-1 -: TAG_SIZE].
REQ-003 SHALL have parameter WORD_SIZE, default 8, data word width.
REQ-004 SHALL have parameter WAYS, default 4, number of lines in the set; power of 2, 2..8.
REQ-005 SHALL have parameter OFFSET_BITS, default 2, word offset addr[OFFSET_BITS-1:0]; line holds 2^OFFSET_BITS words.
REQ-006 SHALL use one clock; reset is asynchronous and active-high.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 addr  in  ADDRESS_WORD_SIZE  request address.
REQ-010 try_read / try_write  in  1 each  request strobes, sampled only when busy=0.
REQ-011 write_data  in  WORD_SIZE  store data.
REQ-012 read_data  out  WORD_SIZE  registered load data, valid while done=1.
REQ-013 hit  out  1  combinational: some way valid and tag-matching addr.
REQ-014 done  out  1  one-cycle pulse on request completion.
REQ-015 busy  out  1  high from miss acceptance until done.
REQ-016 mem_req, mem_we  out  1 each  memory request and write flag; mem_addr  out  ADDRESS_WORD_SIZE; mem_wdata  out  WORD_SIZE.
REQ-017 mem_rdata  in  WORD_SIZE; mem_ack  in  1  one-cycle word acknowledge.

Function
REQ-018 Each way SHALL hold valid, dirty, tag and 2^OFFSET_BITS words.
REQ-019 try_read and try_write together SHALL be treated as a write.
REQ-020 FSM states SHALL be IDLE, EVICT, REFILL, RESPOND.
REQ-021 IDLE hit: next cycle done=1; read → read_data = hit word; write → word updated, dirty set; replacement state touched; no busy.
REQ-022 IDLE miss: request captured (addr, data, kind), busy=1, victim chosen; invalid lowest-index way preferred, else replacement policy.
REQ-023 Victim valid and dirty → EVICT; otherwise → REFILL.
REQ-024 EVICT: mem_req=1, mem_we=1, mem_addr={victim tag, captured addr middle bits, word counter}, mem_wdata = victim word[counter]; counter increments on mem_ack; after last word → REFILL, counter=0.
REQ-025 REFILL: mem_req=1, mem_we=0, mem_addr={captured tag, middle bits, counter}; mem_rdata written to victim word[counter] on mem_ack; after last word → RESPOND.
REQ-026 Entering RESPOND: victim tag=captured tag, valid=1, dirty=0; captured write then applied (dirty=1); done=1 one cycle; read_data = requested word; → IDLE, busy=0.
REQ-027 mem_req SHALL stay high with stable mem_addr/mem_wdata until mem_ack; mem_ack outside EVICT/REFILL ignored.
REQ-028 Requests while busy=1 SHALL be ignored, not queued.
REQ-029 Word counter SHALL be OFFSET_BITS wide, wrap to 0 after 2^OFFSET_BITS-1.
REQ-030 Miss latency SHALL be 1 + evicted words + 2^OFFSET_BITS refill acks + 1 cycle.

Reset
REQ-031 rst SHALL clear all valid, dirty, replacement state, counter; FSM → IDLE.
REQ-032 Outputs under reset: read_data=0, done=0, busy=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; hit=0.
REQ-033 rst mid-miss SHALL abandon the transfer; victim line left invalid; no done pulse.

Configuration
REQ-034 Macro CACHE_SET_LRU_EN defined: true LRU, per-way age counter of log2(WAYS) bits; accessed way → 0, younger ways increment; victim = age WAYS-1.
REQ-035 Macro undefined: round-robin pointer, log2(WAYS) bits, increments (wrapping) on each line allocation; victim = pointer; hits do not update it.

Verification
REQ-036 Reset, read 0x0000_0004 → hit=0, busy=1, 4 REFILL acks with mem_rdata 0x11..0x14, done with read_data=0x11; cycles = 6.
REQ-037 Write 0xA5 to 0x0000_0005 after REQ-036 → hit=1, done next cycle, no mem_req; re-read returns 0xA5.
REQ-038 Fill 4 ways with distinct tags, dirty way 0, miss new tag with LRU → way 0 evicted: 4 EVICT writes (0xA5 at offset 1) then 4 refills.
REQ-039 Same with macro undefined → victim = pointer value 0 after 4 allocations (wrapped).
REQ-040 Assert rst during REFILL word 2 → mem_req=0 next cycle, all ways invalid, subsequent read misses.
REQ-041 try_read and try_write together on hit → write performed, dirty=1; request during busy → no effect.
